// File: rtl/alu_iterative.sv
// alu_iterative: valid/ready datapath ALU with single-cycle ops and an N-step shift-add multiplier.
// Define ALU_ITER_DIV_EN to add the N-step restoring divider for DIVU (11) and REMU (12).
module alu_iterative #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] SrcA,
  input  logic [N-1:0] SrcB,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ALUResult,
  output logic         Zero,
  output logic         Overflow
);
  localparam int unsigned SHW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e         state_q;
  logic [SHW-1:0] count_q;
  logic [N-1:0]   opa_q, opb_q, acc_q;
  logic [N-1:0]   result_q;
  logic           zero_q, ovf_q;

  logic           accept, multi_op, last_step;
  logic [SHW-1:0] shamt;
  logic [N-1:0]   sum, diff, single_res;
  logic           single_ovf;
  logic [N-1:0]   mul_acc_nxt, step_res;
  logic [N-1:0]   opa_step, opb_step, acc_step;

  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid & in_ready;
  assign last_step = (count_q == SHW'(N - 1));
  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;

  assign shamt = SrcB[SHW-1:0];

  always_comb begin
    sum        = SrcA + SrcB;
    diff       = SrcA - SrcB;
    single_res = '0;
    single_ovf = 1'b0;
    case (ALUControl)
      4'd0: begin
        single_res = sum;
        single_ovf = (SrcA[N-1] == SrcB[N-1]) && (sum[N-1] != SrcA[N-1]);
      end
      4'd1: begin
        single_res = diff;
        single_ovf = (SrcA[N-1] != SrcB[N-1]) && (diff[N-1] != SrcA[N-1]);
      end
      4'd2: single_res = SrcA & SrcB;
      4'd3: single_res = SrcA | SrcB;
      4'd4: single_res = SrcA ^ SrcB;
      4'd5: single_res = {{(N-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      4'd6: single_res = {{(N-1){1'b0}}, SrcA < SrcB};
      4'd7: single_res = SrcA << shamt;
      4'd8: single_res = SrcA >> shamt;
      4'd9: single_res = $unsigned($signed(SrcA) >>> shamt);
      default: single_res = '0;
    endcase
  end

  // Multiplier: opa = shifted multiplicand, opb = shifted multiplier, acc = partial product.
  assign mul_acc_nxt = acc_q + (opb_q[0] ? opa_q : '0);

`ifdef ALU_ITER_DIV_EN
  // Divider: opa = dividend shifting into quotient, opb = divisor, acc = remainder.
  logic         div_q, rem_sel_q;
  logic [N:0]   rem_sh;
  logic         rem_ge;
  logic [N-1:0] rem_nxt, quo_nxt;

  assign rem_sh   = {acc_q, opa_q[N-1]};
  assign rem_ge   = rem_sh >= {1'b0, opb_q};
  assign rem_nxt  = rem_ge ? (rem_sh[N-1:0] - opb_q) : rem_sh[N-1:0];
  assign quo_nxt  = {opa_q[N-2:0], rem_ge};
  assign step_res = !div_q ? mul_acc_nxt : (rem_sel_q ? rem_nxt : quo_nxt);
  assign multi_op = ALUControl inside {4'd10, 4'd11, 4'd12};
`else
  assign step_res = mul_acc_nxt;
  assign multi_op = (ALUControl == 4'd10);
`endif

  always_comb begin
    opa_step = {opa_q[N-2:0], 1'b0};
    opb_step = opb_q >> 1;
    acc_step = mul_acc_nxt;
`ifdef ALU_ITER_DIV_EN
    if (div_q) begin
      opa_step = quo_nxt;
      opb_step = opb_q;
      acc_step = rem_nxt;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALU_ITER_DIV_EN
      div_q     <= 1'b0;
      rem_sel_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StBusy: begin
          count_q <= count_q + SHW'(1);
          opa_q   <= opa_step;
          opb_q   <= opb_step;
          acc_q   <= acc_step;
          if (last_step) begin
            result_q <= step_res;
            zero_q   <= (step_res == '0);
            ovf_q    <= 1'b0;
            state_q  <= StDone;
          end
        end
        StIdle, StDone: begin
          if (accept) begin
            if (multi_op) begin
              opa_q   <= SrcA;
              opb_q   <= SrcB;
              acc_q   <= '0;
              count_q <= '0;
              state_q <= StBusy;
`ifdef ALU_ITER_DIV_EN
              div_q     <= (ALUControl != 4'd10);
              rem_sel_q <= (ALUControl == 4'd12);
`endif
            end else begin
              result_q <= single_res;
              zero_q   <= (single_res == '0);
              ovf_q    <= single_ovf;
              state_q  <= StDone;
            end
          end else if ((state_q == StDone) && out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model of the handshake and arithmetic.
module tb_alu_iterative;
  localparam int N = 32;
  localparam longint MaxS = (64'sd1 <<< (N - 1)) - 64'sd1;
  localparam longint MinS = -(64'sd1 <<< (N - 1));
`ifdef ALU_ITER_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, Zero, Overflow;
  logic [N-1:0] SrcA, SrcB, ALUResult;
  logic [3:0]   ALUControl;

  int errors = 0;
  int checks = 0;

  alu_iterative #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .Overflow   (Overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {overflow, result} computed from wide arithmetic.
  function automatic logic [N:0] model(input logic [3:0] op, input logic [N-1:0] a,
                                       input logic [N-1:0] b);
    longint       sa, sb, wide;
    logic [N-1:0] r;
    logic         o;
    logic [2*N-1:0] prod;
    int           sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % N);
    r  = '0;
    o  = 1'b0;
    case (op)
      4'd0: begin wide = sa + sb; r = a + b; o = (wide > MaxS) || (wide < MinS); end
      4'd1: begin wide = sa - sb; r = a - b; o = (wide > MaxS) || (wide < MinS); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? N'(1) : N'(0);
      4'd6: r = (a < b) ? N'(1) : N'(0);
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      4'd9: r = N'(sa >>> sh);
      4'd10: begin prod = (2*N)'(a) * (2*N)'(b); r = prod[N-1:0]; end
      4'd11: if (DivEn) r = (b == 0) ? '1 : a / b;
      4'd12: if (DivEn) r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return {o, r};
  endfunction

  function automatic bit is_multi(input logic [3:0] op);
    return (op == 4'd10) || (DivEn && (op == 4'd11 || op == 4'd12));
  endfunction

  typedef struct {
    logic [N-1:0] res;
    logic         zero;
    logic         ovf;
    int           done_edge;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  bit   model_live = 1'b0;
  bit   post_reset = 1'b0;

  // Compare process: sampled just before each rising edge, then advance the model past it.
  initial begin : monitor
    bit         front_done, exp_ir;
    exp_t       e;
    logic [N:0] m;
    forever begin
      @(negedge clk);
      #4;
      front_done = (q.size() > 0) && (q[0].done_edge <= edge_n);
      exp_ir     = (q.size() == 0) || (front_done && out_ready);
      if (model_live) begin
        chk("out_valid", N'(out_valid), N'(front_done));
        chk("in_ready", N'(in_ready), N'(exp_ir));
        if (front_done) begin
          chk("model result", ALUResult, q[0].res);
          chk("model zero", N'(Zero), N'(q[0].zero));
          chk("model overflow", N'(Overflow), N'(q[0].ovf));
        end
        if (post_reset) begin
          chk("reset ALUResult", ALUResult, '0);
          chk("reset Zero", N'(Zero), '0);
          chk("reset Overflow", N'(Overflow), '0);
          post_reset = 1'b0;
        end
      end
      if (reset) begin
        q.delete();
        model_live = 1'b1;
        post_reset = 1'b1;
      end else if (model_live) begin
        if (front_done && out_ready) void'(q.pop_front());
        if (in_valid && exp_ir) begin
          m           = model(ALUControl, SrcA, SrcB);
          e.res       = m[N-1:0];
          e.ovf       = m[N];
          e.zero      = (m[N-1:0] == '0);
          e.done_edge = edge_n + 1 + (is_multi(ALUControl) ? N : 0);
          q.push_back(e);
        end
      end
      edge_n++;
    end
  end

  // Issues one op with out_ready low and checks the result against literals and latency.
  task automatic run_op(input string name, input logic [3:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] er, input logic ez,
                        input logic eo, input int elat);
    int n, lat, busy_rdy;
    @(negedge clk);
    in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b; out_ready = 1'b0;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
    chk({name, " accept"}, N'(in_ready), N'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; ALUControl = 4'($urandom);
    lat = 0;
    busy_rdy = 0;
    while (!out_valid && lat < 200) begin
      busy_rdy += int'(in_ready);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, " latency"}, N'(lat), N'(elat));
    chk({name, " ready in busy"}, N'(busy_rdy), '0);
    chk({name, " result"}, ALUResult, er);
    chk({name, " zero"}, N'(Zero), N'(ez));
    chk({name, " overflow"}, N'(Overflow), N'(eo));
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [N-1:0] pick();
    logic [N-1:0] s [4];
    s[0] = 32'h8000_0000; s[1] = 32'hFFFF_FFFF; s[2] = 32'h7FFF_FFFF; s[3] = 32'h1;
    case ($urandom % 4)
      0: return N'($urandom % 40);
      1: return s[$urandom % 4];
      default: return N'($urandom);
    endcase
  endfunction

  initial begin : stim
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    SrcA = '0; SrcB = '0; ALUControl = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("pin add", model(4'd0, 32'h7FFF_FFFF, 32'h1), {1'b1, 32'h8000_0000});
    chk("pin sub", model(4'd1, 32'h8000_0000, 32'h1), {1'b1, 32'h7FFF_FFFF});
    chk("pin sra", model(4'd9, 32'h8000_0000, 32'd4), {1'b0, 32'hF800_0000});
    chk("pin mul", model(4'd10, 32'h1_0000, 32'h1_0003), {1'b0, 32'h0003_0000});
    chk("pin sll", model(4'd7, 32'h1, 32'd33), {1'b0, 32'h2});

    run_op("ADD ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 0); drain();
    run_op("SUB zero", 4'd1, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 0); drain();
    run_op("SLT", 4'd5, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 0); drain();
    run_op("SLTU", 4'd6, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 0); drain();
    run_op("SRA", 4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 0); drain();
    run_op("SLL 33", 4'd7, 32'h1, 32'd33, 32'h2, 1'b0, 1'b0, 0); drain();
    run_op("MUL", 4'd10, 32'h1_0000, 32'h1_0003, 32'h0003_0000, 1'b0, 1'b0, N); drain();
    if (DivEn) begin
      run_op("DIVU", 4'd11, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, N); drain();
      run_op("REMU", 4'd12, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, N); drain();
      run_op("DIVU by 0", 4'd11, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, N); drain();
      run_op("REMU by 0", 4'd12, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, N); drain();
    end else begin
      run_op("code 11 off", 4'd11, 32'd100, 32'd7, 32'h0, 1'b1, 1'b0, 0); drain();
      run_op("code 12 off", 4'd12, 32'd100, 32'd7, 32'h0, 1'b1, 1'b0, 0); drain();
    end
    run_op("code 13", 4'd13, 32'd3, 32'd4, 32'h0, 1'b1, 1'b0, 0); drain();

    // Stall for three cycles, then hand over and accept the next op on the same edge.
    run_op("hold SUB", 4'd1, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hold valid", N'(out_valid), N'(1));
      chk("hold result", ALUResult, 32'h0);
      chk("hold zero", N'(Zero), N'(1));
    end
    in_valid = 1'b1; ALUControl = 4'd0; SrcA = 32'd2; SrcB = 32'd3; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b valid", N'(out_valid), N'(1));
    chk("b2b result", ALUResult, 32'd5);
    chk("b2b zero", N'(Zero), N'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset at BUSY cycle 10 of a multiply.
    @(negedge clk);
    in_valid = 1'b1; ALUControl = 4'd10; SrcA = 32'd3; SrcB = 32'd7;
    #1;
    chk("rst mul accept", N'(in_ready), N'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst result", ALUResult, '0);
    chk("rst zero", N'(Zero), '0);
    chk("rst overflow", N'(Overflow), '0);
    chk("rst out_valid", N'(out_valid), '0);
    chk("rst in_ready", N'(in_ready), N'(1));
    repeat (40) @(posedge clk);
    #1;
    chk("rst stays idle", N'(out_valid), '0);

    // Randomized traffic; the monitor checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset      = ($urandom % 500) == 0;
      in_valid   = ($urandom % 3) != 0;
      ALUControl = 4'($urandom % 16);
      SrcA       = pick();
      SrcB       = pick();
      out_ready  = ($urandom % 4) != 0;
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (N + 4) @(negedge clk);
    chk("final drained", N'(out_valid), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
